// File: rtl/window_gen_3x3_stream.sv
// Raster-stream 3x3 window generator built on a pixel shift register.
// Optional BORDER_REPLICATE_EN: clamp out-of-image taps instead of zeroing them.
module window_gen_3x3_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 8,
  localparam int XW   = $clog2(IMG_W),
  localparam int YW   = $clog2(IMG_H)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [XW-1:0]   win_x,
  output logic [YW-1:0]   win_y,
  output logic            busy,
  output logic            frame_done
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int TOTAL = NPIX + IMG_W + 1;
  localparam int SW    = $clog2(TOTAL + 1);
  localparam int SRD   = 2 * IMG_W + 3;

  localparam logic [SW-1:0] S_LAST  = SW'(NPIX - 1);
  localparam logic [SW-1:0] S_END   = SW'(TOTAL);
  localparam logic [SW-1:0] S_PRIME = SW'(IMG_W + 1);
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0] s_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;

  logic [DW-1:0] sr_q [SRD-1];
  logic [DW-1:0] sr_d [SRD];
  logic [DW-1:0] shift_in;
  logic [DW-1:0] tap [9];

  logic adv, shift, clr, produce;
  logic top, bot, lft, rgt;

  logic            win_valid_q;
  logic [9*DW-1:0] win_data_q, win_d;
  logic [XW-1:0]   win_x_q;
  logic [YW-1:0]   win_y_q;

  assign adv     = !win_valid_q || win_ready;
  assign produce = shift && (s_q >= S_PRIME);

  always_comb begin
    state_d  = state_q;
    shift    = 1'b0;
    shift_in = '0;
    clr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (in_valid && adv) begin
          shift    = 1'b1;
          shift_in = in_data;
          if (s_q == S_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (s_q != S_END) shift = adv;
        else if (adv) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        s_q  <= '0;
        cx_q <= '0;
        cy_q <= '0;
      end else begin
        if (shift) s_q <= s_q + SW'(1);
        if (produce) begin
          if (cx_q == X_LAST) begin
            cx_q <= '0;
            cy_q <= (cy_q == Y_LAST) ? '0 : cy_q + YW'(1);
          end else begin
            cx_q <= cx_q + XW'(1);
          end
        end
      end
    end
  end

  // sr_d is the post-shift register; the oldest stage is never stored
  assign sr_d[0] = shift_in;
  for (genvar i = 1; i < SRD; i++) begin : g_sr
    assign sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SRD - 1; i++) sr_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < SRD - 1; i++) sr_q[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < SRD - 1; i++) sr_q[i] <= sr_d[i];
    end
  end

  assign top = (cy_q == '0);
  assign bot = (cy_q == Y_LAST);
  assign lft = (cx_q == '0);
  assign rgt = (cx_q == X_LAST);

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      localparam int IDX = (2 - r) * IMG_W + (2 - c);
      logic ro, co;
      assign ro = (r == 0 && top) || (r == 2 && bot);
      assign co = (c == 0 && lft) || (c == 2 && rgt);
`ifdef BORDER_REPLICATE_EN
      localparam int IR  = IMG_W + (2 - c);
      localparam int IC  = (2 - r) * IMG_W + 1;
      localparam int IRC = IMG_W + 1;
      assign tap[r*3+c] = ro ? (co ? sr_d[IRC] : sr_d[IR])
                             : (co ? sr_d[IC]  : sr_d[IDX]);
`else
      assign tap[r*3+c] = (ro || co) ? '0 : sr_d[IDX];
`endif
    end
  end

  always_comb begin
    win_d = '0;
    for (int k = 0; k < 9; k++) win_d[k*DW +: DW] = tap[k];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_valid_q <= 1'b0;
      win_data_q  <= '0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else if (produce) begin
      win_valid_q <= 1'b1;
      win_data_q  <= win_d;
      win_x_q     <= cx_q;
      win_y_q     <= cy_q;
    end else if (win_ready) begin
      win_valid_q <= 1'b0;
    end
  end

  assign in_ready   = (state_q == RUN) && adv;
  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Directed bench for window_gen_3x3_stream: spot-tap table,
// full-frame model compare, timing, back-pressure and abort sequences.
module tb_window_gen_3x3_stream;
  localparam int W    = 64;
  localparam int H    = 64;
  localparam int NPIX = W * H;
  localparam int CAPN = 20480;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready;
  logic [7:0]  in_data;
  logic        win_valid, win_ready, busy, frame_done;
  logic [71:0] win_data;
  logic [5:0]  win_x, win_y;

  always #5 clk = ~clk;

  window_gen_3x3_stream #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_x(win_x), .win_y(win_y), .busy(busy), .frame_done(frame_done)
  );

  int checks = 0;
  int failures = 0;

  logic [71:0] cap_d [CAPN];
  int cap_x [CAPN];
  int cap_y [CAPN];
  int ncap = 0, ndone = 0, acc_total = 0, viol = 0;
  int cyc = 0, last_acc_cyc = 0;
  int rise_acc_q [$];
  int rise_gap_q [$];
  logic wv_prev = 1'b0;

  always @(negedge clk) begin
    if (win_valid && !wv_prev) begin
      rise_acc_q.push_back(acc_total);
      rise_gap_q.push_back(cyc - last_acc_cyc);
    end
    wv_prev = win_valid;
    if (win_valid && win_ready) begin
      if (ncap < CAPN) begin
        cap_d[ncap] = win_data;
        cap_x[ncap] = int'(win_x);
        cap_y[ncap] = int'(win_y);
      end
      ncap++;
    end
    if (in_valid && in_ready) begin
      acc_total++;
      last_acc_cyc = cyc;
    end
    if (in_ready && win_valid && !win_ready) viol++;
    if (frame_done) ndone++;
    cyc++;
  end

  function automatic logic [7:0] pix(input int mode, input int x, input int y);
    if (mode == 1) return 8'hFF;
    return 8'((x + y) & 255);
  endfunction

  function automatic logic [7:0] exp_tap(input int mode, input int x,
                                         input int y, input int k);
    int xx, yy;
    xx = x + (k - 1) % 3 - 1;
    yy = y + (k - 1) / 3 - 1;
`ifdef BORDER_REPLICATE_EN
    if (xx < 0) xx = 0;
    if (xx > W - 1) xx = W - 1;
    if (yy < 0) yy = 0;
    if (yy > H - 1) yy = H - 1;
`else
    if (xx < 0 || xx > W - 1 || yy < 0 || yy > H - 1) return 8'h00;
`endif
    return pix(mode, xx, yy);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input int mode, input bit rnd, input int stop_after);
    int idx = 0;
    int n = 0;
    bit sp = 1'b0;
    while (idx < stop_after && n < 40000) begin
      in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data   = pix(mode, idx % W, idx / W);
      win_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      start = 1'b0;
      if (idx == 100 && !sp) begin
        start = 1'b1;
        sp = 1'b1;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      tick();
      n++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("pixels_sent", idx, stop_after);
  endtask

  task automatic wait_done(input bit rnd);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40000) begin
      win_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check("frame_done_seen", seen, 1);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("busy_fall", busy, 0);
    tick();
    win_ready = 1'b1;
  endtask

  task automatic check_frame(input string nm, input int mode, input int base);
    int bad = 0;
    check({nm, "_count"}, ncap - base, NPIX);
    for (int n = 0; n < NPIX; n++) begin
      int i;
      i = base + n;
      if (i >= CAPN) begin
        bad++;
        break;
      end
      if (cap_x[i] != n % W || cap_y[i] != n / W) bad++;
      else begin
        for (int k = 1; k <= 9; k++) begin
          if (cap_d[i][(k-1)*8 +: 8] != exp_tap(mode, n % W, n / W, k)) begin
            bad++;
            break;
          end
        end
      end
    end
    check({nm, "_bad_windows"}, bad, 0);
  endtask

  typedef struct {
    int x;
    int y;
    int k;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [$];

  initial begin
    int b1, b2, b3, rb, a1, d1, d2, v2;
    logic [7:0] w00 [9];

`ifdef BORDER_REPLICATE_EN
    w00 = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
`else
    w00 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd1, 8'd2};
`endif
    for (int k = 0; k < 9; k++) vt.push_back('{0, 0, k + 1, w00[k]});
    vt.push_back('{5, 7, 5, 8'd12});
    vt.push_back('{5, 7, 1, 8'd10});
    vt.push_back('{63, 63, 5, 8'd126});
    vt.push_back('{63, 63, 1, 8'd124});
`ifdef BORDER_REPLICATE_EN
    vt.push_back('{63, 63, 9, 8'd126});
    vt.push_back('{63, 63, 3, 8'd125});
    vt.push_back('{63, 63, 6, 8'd126});
`else
    vt.push_back('{63, 63, 3, 8'd0});
    vt.push_back('{63, 63, 6, 8'd0});
    vt.push_back('{63, 63, 7, 8'd0});
    vt.push_back('{63, 63, 8, 8'd0});
    vt.push_back('{63, 63, 9, 8'd0});
`endif

    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_data_nz", longint'(win_data != '0), 0);
    check("rst_win_x", win_x, 0);
    check("rst_win_y", win_y, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    tick();

    in_valid = 1'b1;
    in_data = 8'hAB;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("idle_no_accept", acc_total, 0);

    b1 = ncap;
    rb = rise_acc_q.size();
    a1 = acc_total;
    d1 = ndone;
    pulse_start();
    check("busy_after_start", busy, 1);
    drive(0, 1'b0, NPIX);
    wait_done(1'b0);
    check_frame("f1", 0, b1);
    foreach (vt[j]) begin
      int i;
      i = b1 + vt[j].y * W + vt[j].x;
      check($sformatf("spot_x%0d_y%0d_w%0d", vt[j].x, vt[j].y, vt[j].k),
            cap_d[i][(vt[j].k-1)*8 +: 8], vt[j].exp);
    end
    if (rise_acc_q.size() > rb) begin
      check("first_win_pixel", rise_acc_q[rb] - a1, W + 2);
      check("first_win_gap", rise_gap_q[rb], 1);
    end else begin
      check("first_win_seen", 0, 1);
    end
    check("f1_done_pulses", ndone - d1, 1);

    b2 = ncap;
    d2 = ndone;
    v2 = viol;
    pulse_start();
    drive(0, 1'b1, NPIX);
    wait_done(1'b1);
    check_frame("f2", 0, b2);
    check("f2_stall_viol", viol - v2, 0);
    check("f2_done_pulses", ndone - d2, 1);

    pulse_start();
    drive(0, 1'b0, 2000);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_win_valid", win_valid, 0);
    tick();

    b3 = ncap;
    pulse_start();
    drive(1, 1'b0, NPIX);
    wait_done(1'b0);
    check_frame("f3", 1, b3);
    check("f3_corner_w1", cap_d[b3][7:0], 0);
    check("f3_interior_w1", cap_d[b3 + 10 * W + 10][7:0], 255);
    check("f3_interior_w9", cap_d[b3 + 10 * W + 10][71:64], 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
